uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the UART TX path between N_REQ byte-stream requesters (e.g. CPU console, debug, logger).
//  Round-robin arbitration with packet locking; each granted byte becomes one register write to
//  the UART TX_BUFFER register. Sits between the requesters and the UART write interface.
//  Retries on TX-buffer-full. Caps burst length so no requester starves the others.
// PARAMETERS
//  N_REQ       4   number of requesters (2..8)
//  MAX_BURST   16  max bytes per grant before forced release (1..255)
//  RETRY_GAP   8   idle cycles after write_error_i before reissuing the same byte (1..255)
// PORTS
//  clk_i            in   1        clock
//  rst_n_i          in   1        reset, asynchronous, active-low
//  req_valid_i      in   N_REQ    requester i has a byte on req_data_i[i]
//  req_data_i       in   8*N_REQ  byte of requester i at [8*i +: 8]
//  req_last_i       in   N_REQ    byte is the last of a packet
//  req_ready_o      out  N_REQ    one-hot, 1-cycle pulse: byte of requester i accepted
//  write_o          out  1        UART write strobe, held until write_done_i
//  write_address_o  out  uart_registers_t  always TX_BUFFER
//  write_data_o     out  32       {24'b0, held byte}
//  write_done_i     in   1        UART write completed
//  write_error_i    in   1        UART write rejected (TX buffer full); valid with write_done_i
//  grant_o          out  N_REQ    one-hot current owner, 0 when IDLE
//  busy_o           out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=N_REQ-1, grant_o=0, req_ready_o=0, write_o=0, write_data_o=0,
//   burst_cnt=0, busy_o=0; write_address_o constant TX_BUFFER.
//  States: IDLE, FETCH, WRITE, BACKOFF, (HEADER with option).
//  IDLE: if any req_valid_i, owner = first valid index scanning rr_ptr+1 .. rr_ptr (mod N_REQ,
//   wrap-around); grant_o set next cycle; -> FETCH. No request -> stay.
//  FETCH: when req_valid_i[owner]: latch data/last, pulse req_ready_o[owner] that cycle,
//   burst_cnt++, -> WRITE next cycle. Otherwise wait (packet lock: owner keeps grant).
//  WRITE: write_o=1 until write_done_i. done & !error: if last_q | burst_cnt==MAX_BURST ->
//   release (rr_ptr=owner, burst_cnt=0, grant_o=0) -> IDLE; else -> FETCH.
//   done & error: write_o drops, -> BACKOFF; the same byte is retried, no new fetch.
//  BACKOFF: count RETRY_GAP cycles, -> WRITE with same byte.
//  Latency: req_ready_o pulse to write_o rise = 1 cycle; release to next grant = 2 cycles.
//  Release always re-arbitrates: owner cannot win twice in a row while another is valid.
//  Forced release at MAX_BURST mid-packet: packet resumes on owner's next grant (bytes not
//   reordered); requesters must tolerate interleaving on the wire.
//  req_valid_i of non-owners ignored; requester dropping valid mid-packet = owner waits in FETCH.
//  Reset mid-write: write_o deasserts asynchronously; held byte lost, no req_ready_o replay.
//  write_done_i outside WRITE is ignored.
// CONFIGURATION
//  UART_ARB_TAG_EN defined: on every grant, before first FETCH, HEADER state writes tag byte
//   8'h80|owner (with BACKOFF retry on error); tag does not count in burst_cnt and generates
//   no req_ready_o. IDLE -> HEADER -> FETCH.
//  Not defined: HEADER state absent; only requester bytes reach the UART.
// TESTING
//  Single req0 packet 3 bytes 41,42,43(last), done 1 cycle after write -> 3 writes of
//   0x41,0x42,0x43, 3 ready pulses, grant_o=0001 then 0 -> IDLE.
//  req0..3 all valid, 1-byte packets -> writes in order req0,1,2,3,0,... (rr_ptr rotation).
//  req1 streams 20 bytes no last, req2 valid, MAX_BURST=16 -> 16 req1 bytes, req2 packet,
//   then remaining 4 req1 bytes.
//  write_error_i on 2nd byte 0x55 -> write_o low RETRY_GAP=8 cycles, 0x55 rewritten, no extra ready.
//  Assert rst_n_i low during WRITE -> all outputs at reset values immediately, rr_ptr=N_REQ-1.
//  UART_ARB_TAG_EN, req3 sends 0x10(last) -> writes 0x83 then 0x10; single ready pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter of N_REQ byte streams onto the UART TX_BUFFER write port
//  clk_i, rst_n_i (async, active-low)
//  req_valid_i/req_data_i/req_last_i -> req_ready_o : per-requester byte streams, ready is a one-hot 1-cycle accept pulse
//  write_o/write_address_o/write_data_o <- write_done_i/write_error_i : UART register write, held until done
//  grant_o : one-hot current owner, busy_o : not idle
//  UART_ARB_TAG_EN : when defined, each grant first writes tag byte 8'h80|owner (HEADER state)
package uart_tx_arbiter_pkg;
  typedef enum logic [2:0] {RX_BUFFER = 3'd0, TX_BUFFER = 3'd1, STATUS = 3'd2, CONTROL = 3'd3} uart_registers_t;
endpackage

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int RETRY_GAP = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               write_o,
  output uart_registers_t    write_address_o,
  output logic [31:0]        write_data_o,
  input  logic               write_done_i,
  input  logic               write_error_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);
  localparam int IW = $clog2(N_REQ);
`ifdef UART_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, BACKOFF, HEADER} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, BACKOFF} state_t;
`endif
  state_t state, state_d;
  logic [IW-1:0] owner, rr_ptr, pick;
  logic any_req, fire, rel;
  logic [7:0] burst_cnt, gap_cnt, data_q;
  logic last_q;
`ifdef UART_ARB_TAG_EN
  logic hdr_q;
`endif
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    return (int'(p) + k >= N_REQ) ? IW'(int'(p) + k - N_REQ) : IW'(int'(p) + k);
  endfunction
  // scan downwards so the nearest valid index after rr_ptr is the last one written
  always_comb begin
    pick = rr_ptr;
    any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--)
      if (req_valid_i[wrap_add(rr_ptr, k)]) begin
        pick = wrap_add(rr_ptr, k);
        any_req = 1'b1;
      end
  end
  assign fire = state == FETCH && req_valid_i[owner];
  assign rel = state == WRITE && write_done_i && !write_error_i && (last_q || burst_cnt == 8'(MAX_BURST));
  always_comb begin
    state_d = state;
    unique case (state)
`ifdef UART_ARB_TAG_EN
      IDLE:    if (any_req) state_d = HEADER;
      HEADER:  if (write_done_i) state_d = write_error_i ? BACKOFF : FETCH;
      BACKOFF: if (gap_cnt == 8'(RETRY_GAP - 1)) state_d = hdr_q ? HEADER : WRITE;
`else
      IDLE:    if (any_req) state_d = FETCH;
      BACKOFF: if (gap_cnt == 8'(RETRY_GAP - 1)) state_d = WRITE;
`endif
      FETCH:   if (fire) state_d = WRITE;
      WRITE:   if (write_done_i) state_d = write_error_i ? BACKOFF : (rel ? IDLE : FETCH);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      owner     <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
      burst_cnt <= 8'd0;
      gap_cnt   <= 8'd0;
      data_q    <= 8'd0;
      last_q    <= 1'b0;
`ifdef UART_ARB_TAG_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any_req) begin
        owner <= pick;
`ifdef UART_ARB_TAG_EN
        data_q <= 8'h80 | 8'(pick);
        hdr_q  <= 1'b1;
`endif
      end
`ifdef UART_ARB_TAG_EN
      if (state == HEADER && write_done_i && !write_error_i) hdr_q <= 1'b0;
`endif
      if (fire) begin
        data_q    <= req_data_i[{owner, 3'b000} +: 8];
        last_q    <= req_last_i[owner];
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (rel) begin
        rr_ptr    <= owner;
        burst_cnt <= 8'd0;
      end
      gap_cnt <= state == BACKOFF ? gap_cnt + 8'd1 : 8'd0;
    end
  // outputs decode from state so reset clears them without waiting for a clock
`ifdef UART_ARB_TAG_EN
  assign write_o = state == WRITE || state == HEADER;
`else
  assign write_o = state == WRITE;
`endif
  assign busy_o          = state != IDLE;
  assign grant_o         = busy_o ? N_REQ'(1) << owner : '0;
  assign req_ready_o     = fire ? N_REQ'(1) << owner : '0;
  assign write_address_o = TX_BUFFER;
  assign write_data_o    = {24'b0, data_q};
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random byte streams checked against a packet-level round-robin model
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;
  localparam int N = 4, MB = 16, RG = 8;
  logic clk = 0, rst_n_i = 0;
  logic [N-1:0] req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [8*N-1:0] req_data_i;
  logic write_o, write_done_i, write_error_i, busy_o;
  uart_registers_t write_address_o;
  logic [31:0] write_data_o;
  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .RETRY_GAP(RG)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .write_o(write_o),
    .write_address_o(write_address_o), .write_data_o(write_data_o), .write_done_i(write_done_i),
    .write_error_i(write_error_i), .grant_o(grant_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, nready = 0, nbytes = 0, mptr;
  bit mon_en = 0;
  logic [8:0] rq[N][$];
  logic [8:0] st[N][$];
  logic [10:0] exp_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask
  // each stream ends with a last byte so an owner is never left waiting forever
  task automatic add_pkt(input int i, input int len);
    logic [8:0] w;
    for (int b = 0; b < len; b++) begin
      w = {b == len - 1, 8'($urandom)};
      rq[i].push_back(w);
      st[i].push_back(w);
    end
    nbytes += len;
  endtask
  // packet-level reference: next non-empty stream after the last owner, up to MB bytes or end of packet
  task automatic run_model();
    int o, cnt;
    logic [8:0] w;
    while (1) begin
      o = -1;
      for (int k = 1; k <= N; k++)
        if (o < 0 && st[(mptr + k) % N].size() > 0) o = (mptr + k) % N;
      if (o < 0) break;
`ifdef UART_ARB_TAG_EN
      exp_q.push_back({3'(o), 8'h80 | 8'(o)});
`endif
      cnt = 0;
      w = 9'd0;
      while (!w[8] && cnt < MB) begin
        w = st[o].pop_front();
        exp_q.push_back({3'(o), w[7:0]});
        cnt++;
      end
      mptr = o;
    end
  endtask
  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk(name, 32'(t < 20000), 1);
  endtask
  // requesters: present queue heads; an owner may randomly drop valid mid-packet
  initial begin
    logic [N-1:0] rdy;
    req_valid_i = '0;
    req_data_i = '0;
    req_last_i = '0;
    forever begin
      @(negedge clk);
      rdy = req_ready_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        req_valid_i[i] = rq[i].size() > 0 && (!grant_o[i] || $urandom_range(3) != 0);
        req_data_i[8*i +: 8] = 8'h00;
        req_last_i[i] = 1'b0;
        if (rq[i].size() > 0) begin
          req_data_i[8*i +: 8] = rq[i][0][7:0];
          req_last_i[i] = rq[i][0][8];
        end
      end
    end
  end
  // UART: random completion delay, occasional buffer-full, stray done pulses while idle
  initial begin
    int wc = 0;
    write_done_i = 0;
    write_error_i = 0;
    forever begin
      @(posedge clk);
      #1;
      write_done_i = 0;
      write_error_i = 0;
      if (write_o) begin
        if (wc == 0) begin
          write_done_i = 1;
          write_error_i = $urandom_range(5) == 0;
          wc = $urandom_range(2);
        end else wc--;
      end else if ($urandom_range(7) == 0) begin
        write_done_i = 1;
        write_error_i = $urandom_range(1) == 1;
      end
    end
  end
  // monitor: pops the scoreboard on each completed write
  initial begin
    bit pend_rdy = 0, in_gap = 0;
    int gap = 0;
    logic [7:0] gap_byte = 0;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pend_rdy = 0;
        in_gap = 0;
      end else begin
        if (pend_rdy) chk("ready_to_write", 32'(write_o), 1);
        pend_rdy = req_ready_o != 0;
        if (req_ready_o != 0) begin
          chk("ready_is_owner", 32'(req_ready_o), 32'(grant_o));
          nready++;
        end
        if (in_gap) begin
          if (!write_o) gap++;
          else begin
            chk("backoff_gap", gap, RG);
            chk("retry_byte", write_data_o, {24'b0, gap_byte});
            in_gap = 0;
          end
        end
        if (write_o && write_done_i) begin
          chk("address", 32'(write_address_o), 32'(TX_BUFFER));
          if (write_error_i) begin
            in_gap = 1;
            gap = 0;
            gap_byte = write_data_o[7:0];
          end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got 0x%0h, expected no write", write_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("write_data", write_data_o, {24'b0, e[7:0]});
            chk("write_owner", 32'(grant_o), 32'(1) << e[10:8]);
          end
        end
      end
    end
  end
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", 32'(write_o), 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_data", write_data_o, 0);
    chk("rst_addr", 32'(write_address_o), 32'(TX_BUFFER));
    rst_n_i = 1;
    mon_en = 1;
    mptr = N - 1;
    @(negedge clk);
    add_pkt(1, 20);
    for (int i = 0; i < N; i++)
      for (int p = 0; p < int'($urandom_range(5, 3)); p++)
        add_pkt(i, $urandom_range(3) == 0 ? $urandom_range(24, 17) : $urandom_range(6, 1));
    run_model();
    wait_drain("drain_random");
    @(negedge clk);
    add_pkt(1, 1);
    run_model();
    wait_drain("drain_single");
    chk("ready_count", nready, nbytes);
    add_pkt(2, 3);
    run_model();
    t = 0;
    while (!write_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("write_before_reset", 32'(write_o), 1);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n_i = 0;
    #1;
    chk("async_write", 32'(write_o), 0);
    chk("async_grant", 32'(grant_o), 0);
    chk("async_ready", 32'(req_ready_o), 0);
    chk("async_busy", 32'(busy_o), 0);
    chk("async_data", write_data_o, 0);
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      st[i].delete();
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n_i = 1;
    mptr = N - 1;
    @(negedge clk);
    nready = 0;
    nbytes = 0;
    mon_en = 1;
    for (int i = 0; i < N; i++) add_pkt(i, 1);
    run_model();
    wait_drain("drain_after_reset");
    chk("ready_count_after_reset", nready, nbytes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
